// File: rtl/regfile_wb_arbiter_if.sv
// Write-port bus between the two writeback requesters, the register file and regfile_wb_arbiter.
// Optional read-bypass signals exist only when REGFILE_WB_ARBITER_BYPASS_EN is defined.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              req_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] data_a;
    logic              gnt_a;
    logic              req_m;
    logic [ADDR_W-1:0] addr_m;
    logic [DATA_W-1:0] data_m;
    logic              gnt_m;
    logic              clear_req;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              init_done;
`ifdef REGFILE_WB_ARBITER_BYPASS_EN
    logic [ADDR_W-1:0] raddr;
    logic [DATA_W-1:0] rdata_in;
    logic [DATA_W-1:0] rdata_out;

    modport slave (
        input  req_a, addr_a, data_a, req_m, addr_m, data_m, clear_req, raddr, rdata_in,
        output gnt_a, gnt_m, we, waddr, wdata, init_done, rdata_out
    );
    modport master (
        output req_a, addr_a, data_a, req_m, addr_m, data_m, clear_req, raddr, rdata_in,
        input  gnt_a, gnt_m, we, waddr, wdata, init_done, rdata_out
    );
`else
    modport slave (
        input  req_a, addr_a, data_a, req_m, addr_m, data_m, clear_req,
        output gnt_a, gnt_m, we, waddr, wdata, init_done
    );
    modport master (
        output req_a, addr_a, data_a, req_m, addr_m, data_m, clear_req,
        input  gnt_a, gnt_m, we, waddr, wdata, init_done
    );
`endif
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: round-robin A/M writeback arbitration, clear sequence,
// $zero protection. Define REGFILE_WB_ARBITER_BYPASS_EN to add write-to-read forwarding.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned NUM_REGS       = 32,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    typedef enum logic [0:0] {StClear, StArb} state_t;

    localparam state_t            RST_STATE = CLEAR_ON_RESET ? StClear : StArb;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ptr_q, ptr_d;  // 0: A favoured, 1: M favoured
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              init_done_q, init_done_d;
    logic              gnt_a, gnt_m;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            cnt_q       <= '0;
            ptr_q       <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        gnt_a   = 1'b0;
        gnt_m   = 1'b0;

        unique case (state_q)
            StClear: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                wdata_d = '0;
                if (cnt_q == LAST_ADDR) begin
                    cnt_d   = '0;
                    state_d = StArb;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StArb: begin
                if (bus.clear_req) begin
                    // The restart edge itself launches the WADDR=0 clear write.
                    we_d    = 1'b1;
                    waddr_d = '0;
                    wdata_d = '0;
                    if (NUM_REGS > 1) begin
                        state_d = StClear;
                        cnt_d   = ADDR_W'(1);
                    end
                end else if (init_done_q) begin
                    // Grants wait for INIT_DONE so the last clear write is never overlapped.
                    if (bus.req_a && !(bus.req_m && ptr_q)) begin
                        gnt_a = 1'b1;
                    end else if (bus.req_m) begin
                        gnt_m = 1'b1;
                    end
                    if (gnt_a) begin
                        we_d    = (bus.addr_a != '0);
                        waddr_d = bus.addr_a;
                        wdata_d = bus.data_a;
                        ptr_d   = 1'b1;
                    end else if (gnt_m) begin
                        we_d    = (bus.addr_m != '0);
                        waddr_d = bus.addr_m;
                        wdata_d = bus.data_m;
                        ptr_d   = 1'b0;
                    end
                end
            end
        endcase

        init_done_d = (state_q == StArb) && (state_d == StArb);
    end

    assign bus.gnt_a     = gnt_a;
    assign bus.gnt_m     = gnt_m;
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.init_done = init_done_q;

`ifdef REGFILE_WB_ARBITER_BYPASS_EN
    assign bus.rdata_out = (we_q && (waddr_q == bus.raddr) && (bus.raddr != '0)) ? wdata_q
                                                                               : bus.rdata_in;
`endif
endmodule
